// File: rtl/hamming_rx_checker_pkg.sv
// Shared Hamming(21,16) definitions used by both the link encoder and the receive checker.
// Holds the code geometry, the data-to-position map and the checker state encoding.
package hamming_rx_checker_pkg;

    localparam int CODE_W  = 21;
    localparam int DATA_W  = 16;
    localparam int SYN_W   = 5;
    localparam int NUM_PAR = 5;

    localparam int PARITY_POS [NUM_PAR] = '{1, 2, 4, 8, 16};

    // Syndromes at or above this value name a position that does not exist.
    localparam logic [SYN_W-1:0] UNCORR_MIN = 5'd22;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } chk_state_t;

    function automatic logic is_parity_pos(input int pos);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < NUM_PAR; j++) begin
            if (PARITY_POS[j] == pos) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // 1-based code position carrying data bit idx; data fills non-parity slots in ascending order.
    function automatic int data_pos(input int idx);
        int res;
        int n;
        res = 0;
        n   = 0;
        for (int q = 1; q <= CODE_W; q++) begin
            if (!is_parity_pos(q)) begin
                if (n == idx) begin
                    res = q;
                end
                n++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_lfsr_ref.sv
// Combinational one-step advance of the right-shifting Galois LFSR that produces the link test pattern.
module hamming_lfsr_ref #(
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic [15:0] state_i,
    output logic [15:0] next_o
);

    assign next_o = state_i[0] ? ((state_i >> 1) ^ TAPS) : (state_i >> 1);

endmodule

// File: rtl/hamming_rx_checker.sv
// Hamming(21,16) receiver: syndrome stage, correction stage, then an LFSR checker that
// locks onto the decoded pseudo-random payload and keeps saturating link statistics.
module hamming_rx_checker
    import hamming_rx_checker_pkg::*;
#(
    parameter logic [15:0] LFSR_TAPS = 16'hB400,
    parameter int          LOCK_CNT  = 4,
    parameter int          LOSS_CNT  = 3,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [20:0]       in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    output logic [4:0]        out_syndrome,
    output logic              locked,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count,
    output logic [CNT_W-1:0]  mism_count
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_V = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] LOSS_V = MISS_W'(LOSS_CNT);

    logic                s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0]   s1_code_q, s1_code_d;
    logic [SYN_W-1:0]    s1_syn_q, s1_syn_d;
    logic                s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_corr_q, out_corr_d;
    logic                out_uncorr_q, out_uncorr_d;
    logic [SYN_W-1:0]    out_syn_q, out_syn_d;

    chk_state_t          state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         lfsr_nxt;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [CNT_W-1:0]    corr_q, corr_d;
    logic [CNT_W-1:0]    uncorr_q, uncorr_d;
    logic [CNT_W-1:0]    mism_q, mism_d;

    logic                s1_adv, s2_adv, out_hs, word_match;
    logic                syn_fix, syn_bad;
    logic [SYN_W-1:0]    in_syn;
    logic [CODE_W-1:0]   flip_mask, fixed_code;
    logic [DATA_W-1:0]   fixed_data;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = s2_valid_q && out_ready;

    always_comb begin
        in_syn = '0;
        for (int k = 0; k < CODE_W; k++) begin
            if (in_code[k]) begin
                in_syn ^= SYN_W'(k + 1);
            end
        end
    end

    assign syn_fix = (s1_syn_q != '0) && (s1_syn_q < UNCORR_MIN);
    assign syn_bad = (s1_syn_q >= UNCORR_MIN);

    always_comb begin
        flip_mask = '0;
        if (syn_fix) begin
            flip_mask[s1_syn_q - 5'd1] = 1'b1;
        end
    end

    assign fixed_code = s1_code_q ^ flip_mask;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
            assign fixed_data[gi] = fixed_code[data_pos(gi) - 1];
        end
    endgenerate

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_code_d    = s1_code_q;
        s1_syn_d     = s1_syn_q;
        s2_valid_d   = s2_valid_q;
        out_data_d   = out_data_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        out_syn_d    = out_syn_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code;
                s1_syn_d  = in_syn;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d   = fixed_data;
                out_corr_d   = syn_fix;
                out_uncorr_d = syn_bad;
                out_syn_d    = s1_syn_q;
            end
        end
    end

    hamming_lfsr_ref #(
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .state_i (lfsr_q),
        .next_o  (lfsr_nxt)
    );

    assign word_match = (out_data_q == lfsr_nxt);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        run_d    = run_q;
        miss_d   = miss_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        mism_d   = mism_q;
        if (out_hs) begin
            if (out_corr_q && (corr_q != '1)) begin
                corr_d = corr_q + CNT_W'(1);
            end
            if (out_uncorr_q && (uncorr_q != '1)) begin
                uncorr_d = uncorr_q + CNT_W'(1);
            end
            case (state_q)
                SEEK: begin
                    // A zero seed would freeze the LFSR, so wait for a non-zero word.
                    if (out_data_q != '0) begin
                        lfsr_d  = out_data_q;
                        run_d   = '0;
                        state_d = LOCKING;
                    end
                end
                LOCKING: begin
                    if (word_match) begin
                        lfsr_d = lfsr_nxt;
                        run_d  = run_q + RUN_W'(1);
                        if ((run_q + RUN_W'(1)) == LOCK_V) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        lfsr_d = out_data_q;
                        run_d  = '0;
                    end
                end
                LOCKED: begin
                    lfsr_d = lfsr_nxt;
                    if (!word_match) begin
                        if (mism_q != '1) begin
                            mism_d = mism_q + CNT_W'(1);
                        end
                        if ((miss_q + MISS_W'(1)) == LOSS_V) begin
                            state_d = SEEK;
                            miss_d  = '0;
                            run_d   = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = SEEK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s2_valid_q   <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_syn_q    <= '0;
            state_q      <= SEEK;
            lfsr_q       <= '0;
            run_q        <= '0;
            miss_q       <= '0;
            corr_q       <= '0;
            uncorr_q     <= '0;
            mism_q       <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s2_valid_q   <= s2_valid_d;
            out_data_q   <= out_data_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            out_syn_q    <= out_syn_d;
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            run_q        <= run_d;
            miss_q       <= miss_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            mism_q       <= mism_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = out_data_q;
    assign out_corr     = out_corr_q;
    assign out_uncorr   = out_uncorr_q;
    assign out_syndrome = out_syn_q;
    assign locked       = (state_q == LOCKED);
    assign corr_count   = corr_q;
    assign uncorr_count = uncorr_q;
    assign mism_count   = mism_q;

endmodule
